// File: rtl/block_ram_pkg.sv
// -----------------------------------------------------------------------------
// block_ram_pkg
//   Shared constants and helpers for the block RAM primitive.
//   ADDR_W   : width of the byte/word address presented to the RAM
//   clog2    : ceiling log2, used for constant index-width computation
//   INDEX_W  : number of index bits needed to address SIZE words (min 1)
// -----------------------------------------------------------------------------
package block_ram_pkg;

    localparam int ADDR_W = 32;

    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 32'sd1;
            end
        end
        return result;
    endfunction

    function automatic int INDEX_W(input int size);
        return (clog2(size) < 32'sd1) ? 32'sd1 : clog2(size);
    endfunction

endpackage

// File: rtl/block_ram_if.sv
// -----------------------------------------------------------------------------
// block_ram_if
//   Access bus of the block RAM.
//   i_request : access enable (idle when low, read data holds)
//   i_rw      : 0 = read, 1 = write
//   i_address : address, word index = i_address >> ADDR_LSH
//   i_wdata   : write data
//   o_rdata   : registered read data, valid the cycle after the access
//   master drives the access, slave is the RAM.
// -----------------------------------------------------------------------------
interface block_ram_if
    import block_ram_pkg::*;
#(
    parameter int WIDTH = 32
) ();

    logic              i_request;
    logic              i_rw;
    logic [ADDR_W-1:0] i_address;
    logic [WIDTH-1:0]  i_wdata;
    logic [WIDTH-1:0]  o_rdata;

    modport master (
        output i_request,
        output i_rw,
        output i_address,
        output i_wdata,
        input  o_rdata
    );

    modport slave (
        input  i_request,
        input  i_rw,
        input  i_address,
        input  i_wdata,
        output o_rdata
    );

endinterface

// File: rtl/block_ram_index.sv
// -----------------------------------------------------------------------------
// block_ram_index
//   Converts an address to a word index and flags whether it lands inside the
//   array. Only the low INDEX_W(SIZE) bits of the shifted address are kept, so
//   upper address bits alias; indices >= SIZE (non power-of-two depths) are
//   reported out of range.
//   address_i  : incoming address
//   index_o    : truncated word index
//   in_range_o : 1 when index_o < SIZE
// -----------------------------------------------------------------------------
module block_ram_index
    import block_ram_pkg::*;
#(
    parameter  int SIZE     = 1024,
    parameter  int ADDR_LSH = 2,
    localparam int IW       = INDEX_W(SIZE)
) (
    input  logic [ADDR_W-1:0] address_i,
    output logic [IW-1:0]     index_o,
    output logic              in_range_o
);

    // One extra bit so SIZE == 2**IW does not wrap to zero.
    localparam logic [IW:0] SIZE_L = SIZE[IW:0];

    logic [ADDR_W-1:0] shifted_s;
    logic              unused_shift_s;

    assign shifted_s      = address_i >> ADDR_LSH;
    assign index_o        = shifted_s[IW-1:0];
    assign in_range_o     = ({1'b0, index_o} < SIZE_L);
    // High shifted bits are intentionally discarded.
    assign unused_shift_s = ^shifted_s;

endmodule

// File: rtl/block_ram.sv
// -----------------------------------------------------------------------------
// block_ram
//   Single-port synchronous RAM, one-cycle registered read, no stall.
//   Used as the storage array of the CPU caches.
//   Parameters: WIDTH (word bits), SIZE (words, >= 2), ADDR_LSH (address shift).
//   Ports:
//     i_clock : clock, rising edge
//     i_reset : asynchronous active-low reset; clears o_rdata only, the array
//               keeps its contents and writes are ignored while low
//     bus     : block_ram_if slave (request / rw / address / wdata / rdata)
//   Configuration macro BLOCK_RAM_WRITE_FIRST_EN:
//     defined   -> write-first: a write returns the new data on o_rdata
//     undefined -> read-first:  a write returns the old content on o_rdata
// -----------------------------------------------------------------------------
module block_ram
    import block_ram_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int SIZE     = 1024,
    parameter int ADDR_LSH = 2
) (
    input logic       i_clock,
    input logic       i_reset,
    block_ram_if.slave bus
);

    localparam int IW = INDEX_W(SIZE);

    logic [WIDTH-1:0] mem_q [SIZE];
    logic [WIDTH-1:0] rdata_q;
    logic [IW-1:0]    index_s;
    logic             in_range_s;
    logic             write_en_s;

    block_ram_index #(
        .SIZE     (SIZE),
        .ADDR_LSH (ADDR_LSH)
    ) u_index (
        .address_i  (bus.i_address),
        .index_o    (index_s),
        .in_range_o (in_range_s)
    );

    // Gated by i_reset so writes are dropped while reset is held; the array
    // itself has no reset so it stays mappable to vendor block RAM.
    assign write_en_s = i_reset & bus.i_request & bus.i_rw & in_range_s;

    // Array write port.
    always_ff @(posedge i_clock) begin
        if (write_en_s) begin
            mem_q[index_s] <= bus.i_wdata;
        end
    end

    // Registered read port; out-of-range accesses return zero.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rdata_q <= '0;
        end else if (bus.i_request) begin
            if (!in_range_s) begin
                rdata_q <= '0;
`ifdef BLOCK_RAM_WRITE_FIRST_EN
            end else if (bus.i_rw) begin
                rdata_q <= bus.i_wdata;
`endif
            end else begin
                rdata_q <= mem_q[index_s];
            end
        end
    end

    assign bus.o_rdata = rdata_q;

endmodule

// File: tb/tb_block_ram.sv
module tb_block_ram;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    block_ram_if #(.WIDTH(64)) if_a ();
    block_ram_if #(.WIDTH(32)) if_b ();
    block_ram_if #(.WIDTH(32)) if_c ();

    // 64-bit word-addressed RAM
    block_ram #(.WIDTH(64), .SIZE(16), .ADDR_LSH(0)) dut_a (
        .i_clock (clk), .i_reset (rst_n), .bus (if_a.slave));
    // default 32-bit byte-addressed RAM
    block_ram #(.WIDTH(32), .SIZE(1024), .ADDR_LSH(2)) dut_b (
        .i_clock (clk), .i_reset (rst_n), .bus (if_b.slave));
    // non power-of-two depth
    block_ram #(.WIDTH(32), .SIZE(6), .ADDR_LSH(0)) dut_c (
        .i_clock (clk), .i_reset (rst_n), .bus (if_c.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acc_a(input logic rw, input logic [31:0] addr, input logic [63:0] wd);
        if_a.i_request = 1'b1; if_a.i_rw = rw; if_a.i_address = addr; if_a.i_wdata = wd;
        tick();
        if_a.i_request = 1'b0;
    endtask

    task automatic acc_b(input logic rw, input logic [31:0] addr, input logic [31:0] wd);
        if_b.i_request = 1'b1; if_b.i_rw = rw; if_b.i_address = addr; if_b.i_wdata = wd;
        tick();
        if_b.i_request = 1'b0;
    endtask

    task automatic acc_c(input logic rw, input logic [31:0] addr, input logic [31:0] wd);
        if_c.i_request = 1'b1; if_c.i_rw = rw; if_c.i_address = addr; if_c.i_wdata = wd;
        tick();
        if_c.i_request = 1'b0;
    endtask

    task automatic test_reset();
        // reset state while reset held from time zero
        #1;
        total_cnt++;
        if ({if_a.o_rdata, if_b.o_rdata, if_c.o_rdata} !== 128'd0) begin
            $display("FAIL reset_state: got a=%h b=%h c=%h, expected all zero",
                     if_a.o_rdata, if_b.o_rdata, if_c.o_rdata);
        end else pass_cnt++;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        acc_b(1'b1, 32'h24, 32'h0000CAFE);
        acc_b(1'b0, 32'h24, 32'h0);
        total_cnt++;
        if (if_b.o_rdata !== 32'h0000CAFE) begin
            $display("FAIL reset_pre_read: got %h expected %h", if_b.o_rdata, 32'h0000CAFE);
        end else pass_cnt++;
        // asynchronous assertion between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (if_b.o_rdata !== 32'h0) begin
            $display("FAIL reset_async_clear: got %h expected %h", if_b.o_rdata, 32'h0);
        end else pass_cnt++;
        // write attempted while reset is held must be ignored
        if_b.i_request = 1'b1; if_b.i_rw = 1'b1; if_b.i_address = 32'h24; if_b.i_wdata = 32'h00000BAD;
        tick(); tick();
        total_cnt++;
        if (if_b.o_rdata !== 32'h0) begin
            $display("FAIL reset_hold: got %h expected %h", if_b.o_rdata, 32'h0);
        end else pass_cnt++;
        if_b.i_request = 1'b0;
        rst_n = 1'b1;
        tick();
        acc_b(1'b0, 32'h24, 32'h0);
        total_cnt++;
        if (if_b.o_rdata !== 32'h0000CAFE) begin
            $display("FAIL reset_mem_kept: got %h expected %h", if_b.o_rdata, 32'h0000CAFE);
        end else pass_cnt++;
    endtask

    task automatic test_write_read();
        logic [63:0] exp_w;
`ifdef BLOCK_RAM_WRITE_FIRST_EN
        exp_w = 64'hDEADBEEF_00000010;
`else
        exp_w = 64'h0;
`endif
        acc_a(1'b1, 32'd5, 64'hDEADBEEF_00000010);
        total_cnt++;
        if (if_a.o_rdata !== exp_w) begin
            $display("FAIL wr_rdata_on_write: got %h expected %h", if_a.o_rdata, exp_w);
        end else pass_cnt++;
        acc_a(1'b0, 32'd5, 64'h0);
        total_cnt++;
        if (if_a.o_rdata !== 64'hDEADBEEF_00000010) begin
            $display("FAIL wr_read5: got %h expected %h", if_a.o_rdata, 64'hDEADBEEF_00000010);
        end else pass_cnt++;
        acc_a(1'b1, 32'd6, 64'h11112222_33334444);
    endtask

    task automatic test_back_to_back();
        if_a.i_request = 1'b1; if_a.i_rw = 1'b0; if_a.i_address = 32'd6;
        tick();
        total_cnt++;
        if (if_a.o_rdata !== 64'h11112222_33334444) begin
            $display("FAIL b2b_read6: got %h expected %h", if_a.o_rdata, 64'h11112222_33334444);
        end else pass_cnt++;
        if_a.i_address = 32'd5;
        tick();
        total_cnt++;
        if (if_a.o_rdata !== 64'hDEADBEEF_00000010) begin
            $display("FAIL b2b_read5: got %h expected %h", if_a.o_rdata, 64'hDEADBEEF_00000010);
        end else pass_cnt++;
        if_a.i_address = 32'd7;
        tick();
        if_a.i_request = 1'b0;
        total_cnt++;
        if (if_a.o_rdata !== 64'h0) begin
            $display("FAIL b2b_read7: got %h expected %h", if_a.o_rdata, 64'h0);
        end else pass_cnt++;
    endtask

    task automatic test_addressing();
        acc_b(1'b1, 32'h10, 32'h00001234);
        acc_b(1'b0, 32'h11, 32'h0);
        total_cnt++;
        if (if_b.o_rdata !== 32'h00001234) begin
            $display("FAIL addr_0x11: got %h expected %h", if_b.o_rdata, 32'h00001234);
        end else pass_cnt++;
        acc_b(1'b0, 32'h14, 32'h0);
        total_cnt++;
        if (if_b.o_rdata !== 32'h0) begin
            $display("FAIL addr_0x14: got %h expected %h", if_b.o_rdata, 32'h0);
        end else pass_cnt++;
        acc_b(1'b0, 32'h13, 32'h0);
        total_cnt++;
        if (if_b.o_rdata !== 32'h00001234) begin
            $display("FAIL addr_0x13: got %h expected %h", if_b.o_rdata, 32'h00001234);
        end else pass_cnt++;
    endtask

    task automatic test_read_first();
        logic [31:0] exp_w;
`ifdef BLOCK_RAM_WRITE_FIRST_EN
        exp_w = 32'h5555;
`else
        exp_w = 32'hAAAA;
`endif
        acc_b(1'b1, 32'h0C, 32'h0000AAAA);
        acc_b(1'b1, 32'h0C, 32'h00005555);
        total_cnt++;
        if (if_b.o_rdata !== exp_w) begin
            $display("FAIL rf_write_rdata: got %h expected %h", if_b.o_rdata, exp_w);
        end else pass_cnt++;
        acc_b(1'b0, 32'h0C, 32'h0);
        total_cnt++;
        if (if_b.o_rdata !== 32'h00005555) begin
            $display("FAIL rf_read_after: got %h expected %h", if_b.o_rdata, 32'h00005555);
        end else pass_cnt++;
    endtask

    task automatic test_idle_hold();
        int sel;
        acc_b(1'b1, 32'h40, 32'h00000077);
        acc_b(1'b0, 32'h40, 32'h0);
        for (int k = 0; k < 8; k++) begin
            sel = $urandom_range(0, 2);
            if_b.i_request = 1'b0;
            if_b.i_rw      = 1'($urandom_range(0, 1));
            if_b.i_wdata   = $urandom;
            if_b.i_address = (sel == 0) ? 32'h40 : (sel == 1) ? 32'h0C : 32'($urandom);
            tick();
            total_cnt++;
            if (if_b.o_rdata !== 32'h00000077) begin
                $display("FAIL idle_hold[%0d]: got %h expected %h", k, if_b.o_rdata, 32'h00000077);
            end else pass_cnt++;
        end
        acc_b(1'b0, 32'h0C, 32'h0);
        total_cnt++;
        if (if_b.o_rdata !== 32'h00005555) begin
            $display("FAIL idle_mem_idx3: got %h expected %h", if_b.o_rdata, 32'h00005555);
        end else pass_cnt++;
        acc_b(1'b0, 32'h40, 32'h0);
        total_cnt++;
        if (if_b.o_rdata !== 32'h00000077) begin
            $display("FAIL idle_mem_idx16: got %h expected %h", if_b.o_rdata, 32'h00000077);
        end else pass_cnt++;
    endtask

    task automatic test_range();
        for (int i = 0; i < 6; i++) begin
            acc_c(1'b1, 32'(i), 32'h100 + 32'(i));
        end
        acc_c(1'b1, 32'd7, 32'h0000DEAD);
        acc_c(1'b0, 32'd7, 32'h0);
        total_cnt++;
        if (if_c.o_rdata !== 32'h0) begin
            $display("FAIL range_read7: got %h expected %h", if_c.o_rdata, 32'h0);
        end else pass_cnt++;
        acc_c(1'b0, 32'd6, 32'h0);
        total_cnt++;
        if (if_c.o_rdata !== 32'h0) begin
            $display("FAIL range_read6: got %h expected %h", if_c.o_rdata, 32'h0);
        end else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            acc_c(1'b0, 32'(i), 32'h0);
            total_cnt++;
            if (if_c.o_rdata !== 32'h100 + 32'(i)) begin
                $display("FAIL range_idx%0d: got %h expected %h", i, if_c.o_rdata, 32'h100 + 32'(i));
            end else pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        if_a.i_request = 1'b0; if_a.i_rw = 1'b0; if_a.i_address = '0; if_a.i_wdata = '0;
        if_b.i_request = 1'b0; if_b.i_rw = 1'b0; if_b.i_address = '0; if_b.i_wdata = '0;
        if_c.i_request = 1'b0; if_c.i_rw = 1'b0; if_c.i_address = '0; if_c.i_wdata = '0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_addressing();
        test_read_first();
        test_idle_hold();
        test_range();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
